compressor_arbiter: RTL
=======================

# compressor_arbiter

Shares one registered compressor lookup (10-bit signed in, 9-bit signed out, one clock of latency) between NCH audio sources, e.g. SP0256 speech, PSG and DAC. Arbitration is round-robin with one accept per clock and a fixed three-edge pipeline. Each result returns to its owning channel as a held 9-bit sample plus a one-cycle strobe. The block sits between the sound sources and the output mixer.

## Interface
Parameters:
- NCH, 4: number of requesting channels, 2..8.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NCH  per-channel request; one sample is offered while high.
- req_sample  in  NCH×10  per-channel signed sample.
- req_ready  out  NCH  one-hot grant; the channel's sample is accepted at the clock edge where valid and ready are both high.
- cmp_din  out  10  registered sample driven to the shared compressor.
- cmp_dout  in  9  compressor result; valid one edge after cmp_din.
- out_sample  out  NCH×9  per-channel compressed sample, held between updates.
- out_strobe  out  NCH  one-cycle pulse when that channel's out_sample updates.
- busy  out  1  high while any pipeline stage holds a valid entry.

## Operation
- **Grant logic.** req_ready is combinational from req_valid and the pointer `last`.
  - The first valid channel searching last+1, last+2, … (mod NCH) is granted.
  - At most one bit of req_ready is high.
  - req_ready is all-zero while reset is high or when no channel is valid.
  - On an accept, `last` becomes the granted index.
  - `last` resets to NCH-1, so channel 0 wins the first contention.
- **Stage 0 (accept edge).**
  - cmp_din <= granted sample.
  - s0_tag <= granted index.
  - s0_v <= 1.
  - With no accept: s0_v <= 0 and cmp_din holds its value.
- **Stage 1.** s1_tag <= s0_tag, s1_v <= s0_v, matching the compressor's internal register.
- **Stage 2.**
  - If s1_v: out_sample[s1_tag] <= cmp_dout and out_strobe[s1_tag] <= 1.
  - All other strobe bits <= 0; other channels' samples hold.
- **Bit widths.** No arithmetic is done in this block. Results pass through unmodified at 9 bits, sign in bit 8.
- **busy** = s0_v | s1_v | any out_strobe bit.
- **Dropping requests.** A requester may drop req_valid without being accepted; nothing is queued.
- **Back-to-back accepts.** The same channel may be accepted on consecutive cycles only when it is the sole valid requester.

## Timing
- Accept at edge k:
  - cmp_din is valid after edge k.
  - cmp_dout is valid after edge k+1.
  - out_sample and out_strobe are updated after edge k+2.
  - Latency is 3 edges; throughput is 1 sample per clock.
- **Reset values:**
  - cmp_din = 0, out_sample = 0 for all channels, out_strobe = 0, busy = 0.
  - s0_v = s1_v = 0, last = NCH-1.
- **Reset mid-operation.** In-flight entries are discarded, no strobe fires for them, and out_sample returns to 0.
- **Full contention.** With all NCH channels valid continuously, each channel is accepted exactly once per NCH cycles, in order 0,1,…,NCH-1,0,…
- **Single requester.** A lone requester is granted every cycle, and the pointer still tracks it.
- **Pointer skip.** A valid drop on the pointed channel between cycles skips it with no bubble.

## Structure
- **Package compressor_arb_pkg:**
  - CMP_IN_W = 10, CMP_OUT_W = 9, CMP_LATENCY = 1.
  - NCH_MAX = 8.
  - Function tag_w(n) = $clog2(n) for tag widths.
- **Sub-module rr_arbiter:**
  - Parameter N.
  - Inputs req[N], adv (accept strobe).
  - Outputs grant[N] one-hot and grant_idx.
  - Owns the `last` register with asynchronous reset.
- The pipeline tags and output registers live in compressor_arbiter. The compressor itself is instantiated by the parent, not inside this block.

## Test plan
The bench wires the real compressor to cmp_din and cmp_dout.
1. **Single channel.** Channel 0 sends 10'h010 for one cycle. Required: out_sample[0] = 9'h013 and out_strobe[0] pulses exactly 3 edges after accept; busy then falls.
2. **Sign path.**
   - Channel 1 sends 10'h3FF, requiring 9'h1FF.
   - Then 10'h200, requiring 9'h100.
   - Then 10'h1FF, requiring 9'h0FF.
   - Strobes occur on consecutive cycles.
3. **Full contention, NCH=4.**
   - All channels are valid with sample = 10'h001 × (index+1).
   - Grants cycle 0,1,2,3 repeatedly.
   - Each out_strobe has period 4.
   - out_sample[i] = 9'h001, 9'h002, 9'h003, 9'h004.
4. **Fairness skip.** Channels 2 and 3 are valid with last = 2. Required: channel 3 is granted, then 2, alternating, with no idle cycles.
5. **Reset mid-flight.** Accept channel 0 = 10'h100, then assert reset after 1 edge. Required: no strobe, out_sample[0] = 0, req_ready = 0 during reset, and after release channel 0 wins first.
6. **Hold.** After a strobe, all req_valid go low for 20 cycles. Required: out_sample is unchanged, out_strobe stays 0, and busy is 0.

Source files
------------

// File: rtl/compressor_arb_pkg.sv
// Shared widths and helpers for the compressor arbiter slice.
// The compressor itself is external; only its port widths and latency live here.
package compressor_arb_pkg;

  localparam int CMP_IN_W    = 10;
  localparam int CMP_OUT_W   = 9;
  localparam int CMP_LATENCY = 1;
  localparam int NCH_MAX     = 8;

  typedef logic [CMP_IN_W-1:0]  cmp_in_t;
  typedef logic [CMP_OUT_W-1:0] cmp_out_t;

  // Width of a channel tag; never narrower than one bit.
  function automatic int tag_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over N requesters with a registered last-winner pointer.
// The grant is combinational; the pointer moves only on adv.
module rr_arbiter
  import compressor_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int TW = tag_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  grant,
  output logic [TW-1:0] grant_idx
);

  logic [TW-1:0] last;
  logic          found;
  int            cand;

  // NOTE: every variable gets a default before the search loop, so no latch is inferred.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last) + k) % N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = TW'(cand);
      end
    end
    grant = found ? (N'(1) << grant_idx) : '0;
  end

  // Resetting to N-1 makes channel 0 the first winner.
  // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    last <= TW'(N - 1);
    else if (adv) last <= grant_idx;
  end

endmodule

// File: rtl/compressor_arbiter.sv
// Shares one external registered compressor between NCH sources: accept, compress,
// then return each result to its owning channel as a held sample plus a strobe.
module compressor_arbiter
  import compressor_arb_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NCH-1:0]                    req_valid,
  input  logic [NCH-1:0][CMP_IN_W-1:0]      req_sample,
  output logic [NCH-1:0]                    req_ready,
  output logic [CMP_IN_W-1:0]               cmp_din,
  input  logic [CMP_OUT_W-1:0]              cmp_dout,
  output logic [NCH-1:0][CMP_OUT_W-1:0]     out_sample,
  output logic [NCH-1:0]                    out_strobe,
  output logic                              busy
);

  localparam int TW = tag_w(NCH);

  if (CMP_LATENCY != 1 || NCH < 2 || NCH > NCH_MAX) begin : g_bad_cfg
    $error("compressor_arbiter: unsupported NCH or compressor latency");
  end

  logic [NCH-1:0] grant;
  logic [TW-1:0]  grant_idx;
  logic           accept;
  logic           s0_v, s1_v;
  logic [TW-1:0]  s0_tag, s1_tag;

  rr_arbiter #(.N(NCH)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .adv       (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // grant is already a subset of req_valid, so any ready bit is an accept.
  assign req_ready = reset ? '0 : grant;
  assign accept    = |req_ready;

  // Stage 0: capture the granted sample toward the compressor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_din <= '0;
      s0_tag  <= '0;
      s0_v    <= 1'b0;
    end else begin
      s0_v <= accept;
      if (accept) begin
        cmp_din <= req_sample[grant_idx];
        s0_tag  <= grant_idx;
      end
    end
  end

  // Stage 1: tag shadows the compressor's internal register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_tag <= '0;
      s1_v   <= 1'b0;
    end else begin
      s1_tag <= s0_tag;
      s1_v   <= s0_v;
    end
  end

  // Stage 2: steer the compressor result back to its channel.
  // NOTE: the held samples are reset too, since reset must return every out_sample to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_sample <= '0;
      out_strobe <= '0;
    end else begin
      out_strobe <= '0;
      if (s1_v) begin
        out_sample[s1_tag] <= cmp_dout;
        out_strobe[s1_tag] <= 1'b1;
      end
    end
  end

  assign busy = s0_v | s1_v | (|out_strobe);

endmodule
